// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: registered transmitter with a one-byte hold register,
// and a receiver with a 2-FF input synchronizer, start-glitch rejection and framing check.
module uart_transceiver #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_ready
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  // Leaves STOP one cycle before the nominal bit end so a back-to-back start
  // edge is seen by IDLE on time and receive phase does not drift frame to frame.
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT + HALF_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------------------------------------------------------- transmitter
  state_e           tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             launch;
  logic [7:0]       launch_byte;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    tx_d         = tx_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    launch       = 1'b0;
    launch_byte  = tx_data;

    if (tx_start && tx_state_q != S_IDLE) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    unique case (tx_state_q)
      S_IDLE: begin
        if (tx_start) begin
          launch = 1'b1;
        end else if (hold_valid_q) begin
          launch       = 1'b1;
          launch_byte  = hold_q;
          hold_valid_d = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          // A request arriving in this last cycle supersedes the held byte.
          if (tx_start) begin
            launch       = 1'b1;
            hold_valid_d = 1'b0;
          end else if (hold_valid_q) begin
            launch       = 1'b1;
            launch_byte  = hold_q;
            hold_valid_d = 1'b0;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    if (launch) begin
      tx_state_d = S_START;
      tx_cnt_d   = '0;
      tx_shift_d = launch_byte;
      tx_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the hold register is reset along with its valid flag; it is a
    // single flop word, not a RAM, and a clean value keeps simulation free of X.
    if (reset) begin
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= 3'd0;
      tx_shift_q   <= 8'h00;
      tx_q         <= 1'b1;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_q         <= tx_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign tx = tx_q;

  // ---------------------------------------------------------------- receiver
  logic             rx_meta_q, rx_sync_q;
  state_e           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             stop_ok_q, stop_ok_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_ready_q, rx_ready_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    stop_ok_d  = stop_ok_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = 1'b0;

    unique case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          stop_ok_d = rx_sync_q;
        end
        if (rx_cnt_q == STOP_LAST) begin
          // On a framing error the counter parks here until the line is idle.
          if (stop_ok_q) begin
            rx_data_d  = rx_shift_q;
            rx_ready_d = 1'b1;
            rx_state_d = S_IDLE;
          end else if (rx_sync_q) begin
            rx_state_d = S_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      stop_ok_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_ready_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      stop_ok_q  <= stop_ok_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_ready = rx_ready_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: loopback vector table, hold-register,
// framing-error, glitch and mid-frame reset sequences, with an rx scoreboard.
module tb_uart_transceiver;

  localparam int CLKS  = 50_000_000 / 115200;
  localparam int FRAME = 10 * CLKS;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_line;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx;
  logic [7:0] rx_data;
  logic       rx_ready;

  logic       inject;
  logic       rx_drv;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         pulse_cnt = 0;
  logic       prev_ready = 1'b0;
  logic [7:0] exp_byte;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] tx_byte;
    logic [7:0] exp_rx;
    bit         chk_frame;
  } vec_t;

  vec_t vecs[7];

  always #10 clk = ~clk;

  assign rx_line = inject ? rx_drv : tx;

  uart_transceiver dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx_line),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx       (tx),
    .rx_data  (rx_data),
    .rx_ready (rx_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every rx_ready pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rx_ready) begin
      pulse_cnt++;
      check("rx_ready_single_cycle", {31'b0, prev_ready}, 32'd0);
      check("rx_expected_pending", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        exp_byte = exp_q.pop_front();
        check("rx_data", {24'b0, rx_data}, {24'b0, exp_byte});
      end
    end
    prev_ready = rx_ready;
  end

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n = 0;
    while (pulse_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rx_pulse_count", pulse_cnt, target);
  endtask

  // Called at the first cycle of the start bit; checks the first and last
  // cycle of every bit and that the line is idle right after the stop bit.
  task automatic check_frame(input logic [7:0] b);
    logic [10:0] bits;
    bits = {1'b1, 1'b1, b, 1'b0};
    for (int i = 0; i <= FRAME; i++) begin
      if (i % CLKS == 0 || i % CLKS == CLKS - 1)
        check("tx_frame_bit", {31'b0, tx}, {31'b0, bits[i / CLKS]});
      if (i < FRAME) @(negedge clk);
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (CLKS) @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{8'h48, 8'h48, 1'b1};
    vecs[1] = '{8'h45, 8'h45, 1'b0};
    vecs[2] = '{8'h4C, 8'h4C, 1'b0};
    vecs[3] = '{8'h4C, 8'h4C, 1'b0};
    vecs[4] = '{8'h4F, 8'h4F, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1};

    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    inject   = 1'b0;
    rx_drv   = 1'b1;

    // Reset state
    repeat (8) @(negedge clk);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_rx_ready", {31'b0, rx_ready}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_tx", {31'b0, tx}, 32'd1);
    check("idle_rx_data", {24'b0, rx_data}, 32'h00);
    check("idle_pulses", pulse_cnt, 0);

    // Loopback table: 'H', then "ELLO" each sent as the previous byte arrives, then extremes
    for (int v = 0; v < 7; v++) begin
      exp_q.push_back(vecs[v].exp_rx);
      check("tx_idle_before_start", {31'b0, tx}, 32'd1);
      send(vecs[v].tx_byte);
      if (vecs[v].chk_frame) check_frame(vecs[v].tx_byte);
      else check("tx_start_latency", {31'b0, tx}, 32'd0);
      wait_pulses(v + 1, FRAME + 200);
    end
    check("last_rx_held", {24'b0, rx_data}, 32'hFF);

    // Hold register: 0x11 is overwritten by 0xAA, which follows 0x55 with no idle bit
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send(8'h55);
    repeat (1000) @(negedge clk);
    send(8'h11);
    repeat (999) @(negedge clk);
    send(8'hAA);
    repeat (FRAME - 2001 - 1) @(negedge clk);
    check("hold_stop_last_cycle", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check("hold_no_idle_gap", {31'b0, tx}, 32'd0);
    wait_pulses(9, 2 * FRAME + 200);
    repeat (100) @(negedge clk);
    check("hold_no_extra_byte", pulse_cnt, 9);

    // Short low glitch on rx must not start a frame
    inject = 1'b1;
    rx_drv = 1'b0;
    repeat (CLKS / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (FRAME / 4) @(negedge clk);
    check("glitch_no_pulse", pulse_cnt, 9);

    // Framing error (stop bit 0) is discarded; the next good frame lands
    drive_frame(8'h3C, 1'b0);
    rx_drv = 1'b0;
    repeat (300) @(negedge clk);
    rx_drv = 1'b1;
    repeat (1000) @(negedge clk);
    check("frame_err_no_pulse", pulse_cnt, 9);
    check("frame_err_rx_data_kept", {24'b0, rx_data}, 32'hAA);
    exp_q.push_back(8'h5A);
    drive_frame(8'h5A, 1'b1);
    wait_pulses(10, 1000);
    inject = 1'b0;
    repeat (50) @(negedge clk);

    // Reset mid-transmit of 0xF0 (not expected at the receiver)
    send(8'hF0);
    repeat (1500) @(negedge clk);
    check("pre_reset_tx_low", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    #1;
    check("reset_forces_tx_high", {31'b0, tx}, 32'd1);
    repeat (8) @(negedge clk);
    check("mid_reset_rx_data", {24'b0, rx_data}, 32'h00);
    reset = 1'b0;
    repeat (FRAME / 2) @(negedge clk);
    check("post_reset_tx_idle", {31'b0, tx}, 32'd1);
    check("post_reset_no_pulse", pulse_cnt, 10);
    exp_q.push_back(8'h0F);
    send(8'h0F);
    check_frame(8'h0F);
    wait_pulses(11, 200);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
